// File: rtl/card_dealer_pkg.sv
// Shared constants and types for the card dealer: card encoding, shoe geometry,
// LFSR taps and dealer FSM states.
package card_pkg;

  localparam int CARD_W              = 8;
  localparam int NUM_RANKS           = 13;
  localparam int RANK_ACE            = 1;
  localparam int RANK_JACK           = 11;
  localparam int RANK_QUEEN          = 12;
  localparam int RANK_KING           = 13;
  localparam int CARDS_PER_RANK_DECK = 4;
  localparam int CARDS_PER_DECK      = NUM_RANKS * CARDS_PER_RANK_DECK;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam int                LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_ISSUE = 2'd2
  } dealer_state_t;

  function automatic int cards_left_w(input int num_decks);
    return $clog2(CARDS_PER_DECK * num_decks + 1);
  endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Command/status bundle between game control (master) and the dealer (slave).
interface card_dealer_if
  import card_pkg::*;
#(
  parameter int NUM_DECKS = 1
);

  localparam int CL_W = cards_left_w(NUM_DECKS);

  logic              deal_req_i;
  logic              shuffle_i;
  logic              new_hand_i;
  logic [CARD_W-1:0] data_o;
  logic              save_o;
  logic              busy_o;
  logic              deck_empty_o;
  logic [CL_W-1:0]   cards_left_o;
  logic [3:0]        hand_count_o;
  logic              hand_full_o;

  modport master (
    output deal_req_i, shuffle_i, new_hand_i,
    input  data_o, save_o, busy_o, deck_empty_o, cards_left_o, hand_count_o, hand_full_o
  );

  modport slave (
    input  deal_req_i, shuffle_i, new_hand_i,
    output data_o, save_o, busy_o, deck_empty_o, cards_left_o, hand_count_o, hand_full_o
  );

endinterface

// File: rtl/card_dealer_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes only the low bits used as the
// random rank candidate.
module card_lfsr
  import card_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
  parameter int                OUT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [OUT_W-1:0] rnd_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              fb;

  assign fb     = ^(lfsr_q & LFSR_TAPS);
  assign lfsr_d = en_i ? {lfsr_q[LFSR_W-2:0], fb} : lfsr_q;
  assign rnd_o  = lfsr_q[OUT_W-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/card_dealer.sv
// Draws cards without repetition from a finite shoe and strobes each one out
// on save_o; tracks per-rank stock, shoe level and current hand size.
//
//   state | meaning
//   IDLE  | waiting for an admissible deal request
//   DRAW  | testing random candidates, fallback to lowest stocked rank
//   ISSUE | save_o strobe for the accepted card
module card_dealer
  import card_pkg::*;
#(
  parameter int                NUM_DECKS = 1,
  parameter int                MAX_HAND  = 11,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  parameter int                MAX_RETRY = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  card_dealer_if.slave dl
);

  localparam int CL_W = cards_left_w(NUM_DECKS);
  localparam int RC_W = $clog2(CARDS_PER_RANK_DECK * NUM_DECKS + 1);
  localparam int RT_W = $clog2(MAX_RETRY + 1);

  localparam logic [CL_W-1:0] CARDS_FULL = CL_W'(CARDS_PER_DECK * NUM_DECKS);
  localparam logic [RC_W-1:0] RANK_FULL  = RC_W'(CARDS_PER_RANK_DECK * NUM_DECKS);
  localparam logic [RT_W-1:0] RETRY_MAX  = RT_W'(MAX_RETRY);
  localparam logic [3:0]      HAND_MAX   = 4'(MAX_HAND);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_DRAW  = ST_DRAW;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;

  logic [1:0]        state_q, state_d;
  logic [RT_W-1:0]   retry_q, retry_d;
  logic [CARD_W-1:0] data_q, data_d;
  logic [CL_W-1:0]   cards_left_q, cards_left_d;
  logic [3:0]        hand_q, hand_d;
  logic [RC_W-1:0]   rank_cnt_q [NUM_RANKS];
  logic [RC_W-1:0]   rank_cnt_d [NUM_RANKS];

  logic [3:0] rnd;
  logic [3:0] fb_idx;
  logic [3:0] pick_idx;
  logic       cand_ok;
  logic       fallback;
  logic       deck_empty;
  logic       hand_full;

  card_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (4)
  ) u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (1'b1),
    .rnd_o (rnd)
  );

  assign deck_empty = (cards_left_q == '0);
  assign hand_full  = (hand_q == HAND_MAX);
  assign fallback   = (retry_q == RETRY_MAX);
  assign pick_idx   = fallback ? fb_idx : rnd;

  // Random candidate rank is rnd+1; only indices 0..12 with stock qualify.
  always_comb begin
    cand_ok = 1'b0;
    fb_idx  = '0;
    for (int i = 0; i < NUM_RANKS; i++) begin
      if (rnd == 4'(i) && rank_cnt_q[i] != '0) cand_ok = 1'b1;
    end
    for (int i = NUM_RANKS - 1; i >= 0; i--) begin
      if (rank_cnt_q[i] != '0) fb_idx = 4'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    data_d       = data_q;
    cards_left_d = cards_left_q;
    hand_d       = hand_q;
    rank_cnt_d   = rank_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (dl.deal_req_i && !deck_empty && !hand_full) begin
          state_d = S_DRAW;
          retry_d = '0;
        end
      end
      S_DRAW: begin
        if (fallback || cand_ok) begin
          data_d       = CARD_W'(pick_idx) + CARD_W'(RANK_ACE);
          cards_left_d = cards_left_q - CL_W'(1);
          for (int i = 0; i < NUM_RANKS; i++) begin
            if (pick_idx == 4'(i)) rank_cnt_d[i] = rank_cnt_q[i] - RC_W'(1);
          end
          state_d = S_ISSUE;
        end else begin
          retry_d = retry_q + RT_W'(1);
        end
      end
      S_ISSUE: begin
        hand_d  = hand_q + 4'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A card issued alongside new_hand opens the new hand.
    if (dl.new_hand_i) hand_d = (state_q == S_ISSUE) ? 4'd1 : 4'd0;

    if (dl.shuffle_i) begin
      state_d      = S_IDLE;
      retry_d      = '0;
      data_d       = data_q;
      cards_left_d = CARDS_FULL;
      hand_d       = '0;
      for (int i = 0; i < NUM_RANKS; i++) rank_cnt_d[i] = RANK_FULL;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      retry_q      <= '0;
      data_q       <= '0;
      cards_left_q <= CARDS_FULL;
      hand_q       <= '0;
      for (int i = 0; i < NUM_RANKS; i++) rank_cnt_q[i] <= RANK_FULL;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      data_q       <= data_d;
      cards_left_q <= cards_left_d;
      hand_q       <= hand_d;
      rank_cnt_q   <= rank_cnt_d;
    end
  end

  assign dl.data_o       = data_q;
  assign dl.save_o       = (state_q == S_ISSUE);
  assign dl.busy_o       = (state_q != S_IDLE);
  assign dl.deck_empty_o = deck_empty;
  assign dl.cards_left_o = cards_left_q;
  assign dl.hand_count_o = hand_q;
  assign dl.hand_full_o  = hand_full;

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: a table of command sequences with fixed expected
// counters, multi-cycle corner sequences, then random commands against a shoe model.
`timescale 1ns/1ps
module tb_card_dealer;
  import card_pkg::*;

  localparam int NUM_DECKS = 1;
  localparam int MAX_HAND  = 11;
  localparam int MAX_RETRY = 16;
  localparam int FULL      = 52 * NUM_DECKS;
  localparam int PER_RANK  = 4 * NUM_DECKS;
  localparam int LAT_MAX   = 2 + MAX_RETRY;

  typedef enum int {OP_DEAL, OP_IGN, OP_NH, OP_SHUF, OP_SHUF_DRAW} op_e;
  typedef struct {
    op_e op;
    int  rep;
    int  exp_left;
    int  exp_hand;
    int  exp_full;
    int  exp_empty;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  card_dealer_if #(.NUM_DECKS(NUM_DECKS)) bus ();

  card_dealer #(
    .NUM_DECKS (NUM_DECKS),
    .MAX_HAND  (MAX_HAND),
    .LFSR_SEED (16'hACE1),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .dl    (bus.slave)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int rank_left [1:13];
  int m_left, m_hand, m_last;

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 1; r <= 13; r++) rank_left[r] = PER_RANK;
    m_left = FULL;
    m_hand = 0;
  endtask

  function automatic int lowest_rank();
    for (int r = 1; r <= 13; r++) if (rank_left[r] > 0) return r;
    return 0;
  endfunction

  task automatic check_state(input string name);
    chk({name, ".cards_left"}, int'(bus.cards_left_o), m_left);
    chk({name, ".hand_count"}, int'(bus.hand_count_o), m_hand);
    chk({name, ".hand_full"},  int'(bus.hand_full_o), int'(m_hand == MAX_HAND));
    chk({name, ".deck_empty"}, int'(bus.deck_empty_o), int'(m_left == 0));
    chk({name, ".save"},       int'(bus.save_o), 0);
    chk({name, ".busy"},       int'(bus.busy_o), 0);
    chk({name, ".data"},       int'(bus.data_o), m_last);
  endtask

  // Validate one observed card against the shoe and remove it from the model.
  task automatic take_card(input string name, input int card, input int lat);
    chk({name, ".rank_range"}, int'(card >= 1 && card <= 13), 1);
    if (card >= 1 && card <= 13) begin
      chk({name, ".in_stock"}, int'(rank_left[card] > 0), 1);
      if (lat == LAT_MAX) chk({name, ".fallback_rank"}, card, lowest_rank());
      if (rank_left[card] > 0) rank_left[card]--;
    end
    m_left--;
    m_last = card;
  endtask

  // corner: 0 plain, 1 new_hand during ISSUE, 2 shuffle during ISSUE
  task automatic deal(input string name, input int corner);
    int card, lat;
    card = -1;
    lat  = -1;
    @(negedge clk); bus.deal_req_i = 1'b1;
    @(negedge clk); bus.deal_req_i = 1'b0;
    for (int n = 1; n <= LAT_MAX + 4; n++) begin
      if (bus.save_o) begin
        card = int'(bus.data_o);
        lat  = n;
        break;
      end
      @(negedge clk);
    end
    chk({name, ".latency_ok"}, int'(lat >= 2 && lat <= LAT_MAX), 1);
    if (lat < 0) return;
    take_card(name, card, lat);
    if (corner == 1) bus.new_hand_i = 1'b1;
    if (corner == 2) bus.shuffle_i  = 1'b1;
    @(negedge clk);
    bus.new_hand_i = 1'b0;
    bus.shuffle_i  = 1'b0;
    if (corner == 2)      model_reset();
    else if (corner == 1) m_hand = 1;
    else                  m_hand++;
    check_state(name);
  endtask

  task automatic req_ignored(input string name);
    @(negedge clk); bus.deal_req_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk({name, ".no_save"}, int'(bus.save_o), 0);
      chk({name, ".idle"},    int'(bus.busy_o), 0);
    end
    bus.deal_req_i = 1'b0;
    check_state(name);
  endtask

  task automatic pulse_new_hand(input string name);
    @(negedge clk); bus.new_hand_i = 1'b1;
    @(negedge clk); bus.new_hand_i = 1'b0;
    m_hand = 0;
    check_state(name);
  endtask

  task automatic pulse_shuffle(input string name);
    @(negedge clk); bus.shuffle_i = 1'b1;
    @(negedge clk); bus.shuffle_i = 1'b0;
    model_reset();
    check_state(name);
  endtask

  task automatic shuffle_in_draw(input string name);
    @(negedge clk); bus.deal_req_i = 1'b1;
    @(negedge clk); bus.deal_req_i = 1'b0;
    chk({name, ".busy_in_draw"}, int'(bus.busy_o), 1);
    bus.shuffle_i = 1'b1;
    @(negedge clk); bus.shuffle_i = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk({name, ".aborted"}, int'(bus.save_o), 0);
      @(negedge clk);
    end
    model_reset();
    check_state(name);
  endtask

  task automatic apply(input op_e op, input string name);
    case (op)
      OP_DEAL:      deal(name, 0);
      OP_IGN:       req_ignored(name);
      OP_NH:        pulse_new_hand(name);
      OP_SHUF:      pulse_shuffle(name);
      OP_SHUF_DRAW: shuffle_in_draw(name);
      default:      ;
    endcase
  endtask

  task automatic held_request();
    int t0, t1, c0, c1;
    t0 = -1; t1 = -1; c0 = 0; c1 = 0;
    @(negedge clk); bus.deal_req_i = 1'b1;
    for (int n = 1; n <= 2 * LAT_MAX + 6; n++) begin
      @(negedge clk);
      if (bus.save_o) begin
        if (t0 < 0) begin
          t0 = n; c0 = int'(bus.data_o);
        end else begin
          t1 = n; c1 = int'(bus.data_o);
          bus.deal_req_i = 1'b0;
          break;
        end
      end
    end
    bus.deal_req_i = 1'b0;
    chk("held.first_latency_ok", int'(t0 >= 2 && t0 <= LAT_MAX), 1);
    chk("held.gap_ok", int'(t1 > 0 && t1 - t0 >= 3 && t1 - t0 <= LAT_MAX + 1), 1);
    if (t0 > 0) begin take_card("held.c0", c0, t0); m_hand++; end
    if (t1 > 0) begin take_card("held.c1", c1, t1 - t0 - 1); m_hand++; end
    @(negedge clk);
    check_state("held");
  endtask

  task automatic reset_mid_deal();
    @(negedge clk); bus.deal_req_i = 1'b1;
    @(negedge clk); bus.deal_req_i = 1'b0;
    chk("arst.busy_before", int'(bus.busy_o), 1);
    #1 rst = 1'b1;
    #1;
    model_reset();
    m_last = 0;
    chk("arst.save",       int'(bus.save_o), 0);
    chk("arst.busy",       int'(bus.busy_o), 0);
    chk("arst.cards_left", int'(bus.cards_left_o), m_left);
    chk("arst.hand",       int'(bus.hand_count_o), 0);
    chk("arst.data",       int'(bus.data_o), 0);
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("arst.no_save", int'(bus.save_o), 0);
    end
    check_state("arst");
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1;
    bus.deal_req_i = 1'b0;
    bus.shuffle_i  = 1'b0;
    bus.new_hand_i = 1'b0;
    model_reset();
    m_last = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_state("reset");

    tbl.push_back('{OP_DEAL,       1, 51,  1, 0, 0});
    tbl.push_back('{OP_DEAL,      10, 41, 11, 1, 0});
    tbl.push_back('{OP_IGN,        1, 41, 11, 1, 0});
    tbl.push_back('{OP_NH,         1, 41,  0, 0, 0});
    tbl.push_back('{OP_DEAL,       1, 40,  1, 0, 0});
    tbl.push_back('{OP_SHUF_DRAW,  1, 52,  0, 0, 0});
    tbl.push_back('{OP_DEAL,       3, 49,  3, 0, 0});
    tbl.push_back('{OP_SHUF,       1, 52,  0, 0, 0});
    tbl.push_back('{OP_DEAL,      11, 41, 11, 1, 0});
    tbl.push_back('{OP_NH,         1, 41,  0, 0, 0});
    tbl.push_back('{OP_DEAL,      11, 30, 11, 1, 0});
    tbl.push_back('{OP_NH,         1, 30,  0, 0, 0});
    tbl.push_back('{OP_DEAL,      11, 19, 11, 1, 0});
    tbl.push_back('{OP_NH,         1, 19,  0, 0, 0});
    tbl.push_back('{OP_DEAL,      11,  8, 11, 1, 0});
    tbl.push_back('{OP_NH,         1,  8,  0, 0, 0});
    tbl.push_back('{OP_DEAL,       8,  0,  8, 0, 1});
    tbl.push_back('{OP_IGN,        1,  0,  8, 0, 1});

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].rep; k++) apply(tbl[i].op, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.exp_left", i),  int'(bus.cards_left_o), tbl[i].exp_left);
      chk($sformatf("tbl%0d.exp_hand", i),  int'(bus.hand_count_o), tbl[i].exp_hand);
      chk($sformatf("tbl%0d.exp_full", i),  int'(bus.hand_full_o),  tbl[i].exp_full);
      chk($sformatf("tbl%0d.exp_empty", i), int'(bus.deck_empty_o), tbl[i].exp_empty);
    end
    for (int r = 1; r <= 13; r++) chk($sformatf("shoe_exhausted.rank%0d", r), rank_left[r], 0);

    pulse_shuffle("refill");
    held_request();
    deal("newhand_in_issue", 1);
    deal("plain_after_nh", 0);
    deal("shuffle_in_issue", 2);
    reset_mid_deal();

    for (int i = 0; i < 250; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 75) begin
        if (m_left == 0 || m_hand == MAX_HAND) req_ignored("rnd_ign");
        else deal("rnd_deal", (r < 4) ? 1 : ((r == 4) ? 2 : 0));
      end else if (r < 95) begin
        pulse_new_hand("rnd_nh");
      end else if (r < 97) begin
        pulse_shuffle("rnd_shuf");
      end else if (m_left != 0 && m_hand != MAX_HAND) begin
        shuffle_in_draw("rnd_shuf_draw");
      end else begin
        pulse_shuffle("rnd_shuf2");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Source end of the card-save interface. Draws cards from a finite shoe with no card repeated, then presents each card on data_o with a one-cycle save_o strobe. These connect directly to a card stack's data/save inputs.
- Tracks the remaining count of every rank, cards left in the shoe, and cards dealt to the current hand (at most MAX_HAND).
- Sits between game control, which issues deal/shuffle/new-hand commands, and the per-player card stacks.

Parameters:
- NUM_DECKS, 1, number of 52-card decks in the shoe (1..4).
- MAX_HAND, 11, maximum cards per hand; matches card stack depth.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.
- MAX_RETRY, 16, rejected random draws allowed before the deterministic fallback.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- deal_req_i  in  1  request one card; level sampled each cycle in IDLE.
- shuffle_i  in  1  refill the shoe and clear the hand; highest priority.
- new_hand_i  in  1  clear hand_count_o.
- data_o  out  8  card rank: 1=Ace, 2..10, 11=J, 12=Q, 13=K.
- save_o  out  1  one-cycle strobe; data_o is valid in the same cycle.
- busy_o  out  1  high while not in IDLE.
- deck_empty_o  out  1  cards_left_o == 0.
- cards_left_o  out  clog2(52*NUM_DECKS+1)  cards remaining in the shoe.
- hand_count_o  out  4  cards dealt to the current hand.
- hand_full_o  out  1  hand_count_o == MAX_HAND.

Behaviour:
- Reset values:
  - data_o = 0, save_o = 0, busy_o = 0, deck_empty_o = 0.
  - cards_left_o = 52*NUM_DECKS, hand_count_o = 0, hand_full_o = 0.
  - Every rank count = 4*NUM_DECKS.
  - LFSR = LFSR_SEED, state = IDLE, retry count = 0.
- LFSR:
  - 16-bit Fibonacci LFSR with taps 16,14,13,11.
  - Advances every cycle, including IDLE; shuffle_i does not reload it.
- State machine (IDLE, DRAW, ISSUE):
  - IDLE: if deal_req_i && !deck_empty_o && !hand_full_o && !shuffle_i, go to DRAW with retry count = 0. Otherwise stay in IDLE.
  - DRAW, candidate rank = lfsr[3:0] + 1:
    - If the candidate is 1..13 and its count is > 0: accept it, register data_o, decrement that rank count and cards_left_o, go to ISSUE.
    - Otherwise: increment retry count and stay in DRAW.
    - When retry count == MAX_RETRY, the random candidate is ignored. The lowest rank with count > 0 is chosen (priority encoder) and always accepted.
  - ISSUE: save_o = 1 for exactly this cycle, hand_count_o increments, go to IDLE.
- Latency:
  - deal_req_i sampled at edge k gives save_o high in cycle k+2 on first-try acceptance.
  - Each reject adds 1 cycle; worst case is k+2+MAX_RETRY.
- Deal rate: at most one save_o per 3 cycles. A deal_req_i still held in IDLE after ISSUE starts a new deal.
- data_o holds the last dealt card until the next accept; save_o is 0 outside ISSUE.
- Request gating:
  - deal_req_i is ignored while busy, when the deck is empty, or when the hand is full. No save_o is produced and no counters change.
- shuffle_i, in any state:
  - Next cycle: every rank count = 4*NUM_DECKS, cards_left_o = 52*NUM_DECKS, hand_count_o = 0, state = IDLE.
  - An in-flight DRAW is aborted with no save_o.
  - If asserted in the ISSUE cycle, that save_o still fires, but the hand and shoe end up freshly reset.
  - Beats deal_req_i and new_hand_i in the same cycle.
- new_hand_i:
  - hand_count_o = 0.
  - If coincident with ISSUE, hand_count_o = 1; the issued card belongs to the new hand.
- deck_empty_o and hand_full_o are combinational from registered counts.
- Asynchronous reset mid-deal: everything returns to reset values immediately and no save_o is produced.

Decomposition:
- Package card_pkg:
  - CARD_W = 8, NUM_RANKS = 13.
  - RANK_ACE = 1, RANK_JACK = 11, RANK_QUEEN = 12, RANK_KING = 13.
  - CARDS_PER_RANK_DECK = 4, LFSR tap constants.
  - State enum dealer_state_t.
- Sub-module card_lfsr: 16-bit LFSR with seed parameter, enable tied high.
- Rank counters and the fallback priority encoder stay inline.

Test Plan:
- Reset release -> cards_left_o = 52, hand_count_o = 0, save_o = 0, busy_o = 0.
- Single deal_req_i pulse -> exactly one save_o. It appears 2..18 cycles later, data_o is in 1..13, and cards_left_o = 51 and hand_count_o = 1 in the following cycle.
- 52 deals with new_hand_i after every 11 -> each rank appears exactly 4 times and deck_empty_o = 1. A 53rd request gives no save_o and busy_o stays 0.
- 11 deals without new_hand_i -> hand_full_o = 1 and a 12th request is ignored. Then new_hand_i -> hand_count_o = 0 and deals resume.
- shuffle_i in the cycle after deal_req_i (during DRAW) -> no save_o, cards_left_o = 52, hand_count_o = 0, state IDLE.
- Deal 48 cards, then 4 more -> every deal completes within 18 cycles (exercises the fallback), and the final shoe empties with all ranks at 0.
